pmem_burst_responder: RTL and testbench
=======================================

// Module: pmem_burst_responder
// PURPOSE
// - Memory-side end of the 64-bit burst physical-memory interface driven by cacheline_adaptor.
// - Accepts one 256-bit line read or write per request and answers after a fixed latency.
// - Each line moves as 4 consecutive 64-bit beats qualified by pmem_resp.
// - Backs a small line-addressed store; used as the synthesizable pmem for cpu-level sims.
// PARAMETERS
// - LINE_IDX_BITS  default 8   log2(number of 32-byte lines stored); 8 -> 8 KiB.
// - LATENCY        default 10  cycles from request acceptance to first resp beat; legal >= 1.
// PORTS
// - clk           in   1   clock, all logic on rising edge.
// - rst           in   1   synchronous, active-high reset.
// - pmem_read     in   1   line read request; held by requester until its 4th resp beat.
// - pmem_write    in   1   line write request; held by requester until its 4th resp beat.
// - pmem_address  in   32  line byte address; bits [4:0] expected 0.
// - pmem_wdata    in   64  write beat; sampled on each edge where pmem_resp=1 during a write.
// - pmem_rdata    out  64  read beat; valid only while pmem_resp=1, else 64'h0.
// - pmem_resp     out  1   beat strobe; high exactly 4 consecutive cycles per request.
// - pmem_err      out  1   sticky protocol-error flag (see CONFIGURATION).
// BEHAVIOUR
// - Reset: state=IDLE, pmem_resp=0, pmem_rdata=0, pmem_err=0, beat/latency counters=0.
//   Store contents are NOT cleared.
// - Reset asserted mid-operation aborts the burst; outputs return to reset values next cycle.
//   Beats already written stay written.
// - Line index = pmem_address[LINE_IDX_BITS+4:5]; higher address bits alias (wrap).
// - Beat k (0..3) = line bits [64k+63:64k] = byte offset 8k.
// - FSM states:
//   - IDLE: on edge with read|write high, latch address/op; if both high, write wins.
//     Go to WAIT if LATENCY>1, else BURST.
//   - WAIT: down-counter loaded with LATENCY-1 at acceptance; go to BURST when it reaches 1.
//     First beat appears exactly LATENCY cycles after the accepting edge.
//   - BURST: pmem_resp=1 for beats 0..3 on consecutive cycles, 2-bit beat counter.
//     Read: pmem_rdata = store[idx][beat], registered so rdata aligns with resp.
//     Write: on each resp edge, store[idx][beat] <= pmem_wdata.
//     After beat 3 go to DONE.
//   - DONE: pmem_resp=0; stay until pmem_read=0 and pmem_write=0, then IDLE.
//     Requester must drop its request after beat 3. Back-to-back requests need >=1 idle cycle.
// - Latched address/op are used for the whole transaction.
//   Input changes during WAIT/BURST are ignored.
// - Write then read of the same line returns the written data.
//   There is no bypass, because the transactions are serialized.
// CONFIGURATION
// - PMEM_PROTOCOL_CHECK_EN defined: pmem_err sets (sticky until rst) on any of:
//   - read and write both high at acceptance;
//   - pmem_address[4:0] != 0 at acceptance;
//   - request dropped, op changed, or address changed during WAIT or BURST.
//   Behaviour of the data path is unchanged.
// - PMEM_PROTOCOL_CHECK_EN undefined: pmem_err tied 0; no check logic is built.
// TESTING
// - Reset, then idle 20 cycles -> pmem_resp=0, pmem_rdata=0 every cycle.
// - Write line addr 0x0000_0040, beats 0x11..,0x22..,0x33..,0x44.., LATENCY=10:
//   - resp is high on cycles 10-13 after acceptance;
//   - then read 0x40 returns the same 4 beats in order, resp 4 cycles.
// - Write addr 0x0000_2040 with LINE_IDX_BITS=8 -> read 0x0000_0040 returns that data (alias wrap).
// - Read and write high together at acceptance, with PMEM_PROTOCOL_CHECK_EN defined:
//   - write is performed;
//   - pmem_err=1 and stays 1 until rst.
// - Assert rst during beat 2 of a write:
//   - resp=0 next cycle;
//   - a later read shows beats 0-1 new, beats 2-3 old.
// - LATENCY=1 build: read accepted at edge t -> resp high cycles t+1..t+4.
//   Requester holding read through DONE for 3 cycles yields no second burst.

Source files
------------

// File: rtl/pmem_burst_responder.sv
// rtl/pmem_burst_responder.sv - fixed-latency 4-beat burst memory responder for the 64-bit pmem bus.
// Optional sticky protocol checker on pmem_err: define PMEM_PROTOCOL_CHECK_EN.
module pmem_burst_responder #(
    parameter int LINE_IDX_BITS = 8,
    parameter int LATENCY       = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pmem_read,
    input  logic        pmem_write,
    input  logic [31:0] pmem_address,
    input  logic [63:0] pmem_wdata,
    output logic [63:0] pmem_rdata,
    output logic        pmem_resp,
    output logic        pmem_err
);

    localparam int WORDS = 1 << (LINE_IDX_BITS + 2);
    localparam int CW    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, BURST, DONE} state_t;

    state_t                   state_q;
    logic [LINE_IDX_BITS-1:0] idx_q;
    logic                     is_wr_q;
    logic [1:0]               beat_q;
    logic [CW-1:0]            cnt_q;
    logic                     resp_q;
    logic [63:0]              rdata_q;

    logic [63:0] mem [WORDS];

    logic [LINE_IDX_BITS-1:0] req_idx;
    logic [1:0]               beat_d;
    logic [LINE_IDX_BITS+1:0] rd_addr;
    logic                     mem_we;
    logic                     req_any;

    assign req_idx = pmem_address[LINE_IDX_BITS+4:5];
    assign req_any = pmem_read | pmem_write;
    assign beat_d  = beat_q + 2'd1;

    // Word to present on the next resp cycle; rdata is registered so it lands with resp.
    always_comb begin
        rd_addr = {idx_q, beat_d};
        if (state_q == IDLE) begin
            rd_addr = {req_idx, 2'b00};
        end else if (state_q == WAIT) begin
            rd_addr = {idx_q, 2'b00};
        end
    end

    assign mem_we = !rst && (state_q == BURST) && is_wr_q;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[{idx_q, beat_q}] <= pmem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            resp_q  <= 1'b0;
            rdata_q <= 64'h0;
            beat_q  <= 2'd0;
            cnt_q   <= '0;
            idx_q   <= '0;
            is_wr_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_any) begin
                        idx_q   <= req_idx;
                        is_wr_q <= pmem_write;
                        beat_q  <= 2'd0;
                        if (LATENCY > 1) begin
                            state_q <= WAIT;
                            cnt_q   <= CNT_LOAD;
                        end else begin
                            state_q <= BURST;
                            resp_q  <= 1'b1;
                            rdata_q <= mem[rd_addr];
                        end
                    end
                end
                WAIT: begin
                    if (cnt_q == CW'(1)) begin
                        state_q <= BURST;
                        resp_q  <= 1'b1;
                        rdata_q <= mem[rd_addr];
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                BURST: begin
                    if (beat_q == 2'd3) begin
                        state_q <= DONE;
                        resp_q  <= 1'b0;
                        rdata_q <= 64'h0;
                        beat_q  <= 2'd0;
                    end else begin
                        beat_q  <= beat_d;
                        rdata_q <= mem[rd_addr];
                    end
                end
                DONE: begin
                    if (!req_any) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign pmem_resp  = resp_q;
    assign pmem_rdata = rdata_q;

`ifdef PMEM_PROTOCOL_CHECK_EN
    logic        err_q;
    logic [1:0]  req_q;
    logic [31:0] addr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q  <= 1'b0;
            req_q  <= 2'b00;
            addr_q <= 32'h0;
        end else begin
            if (state_q == IDLE && req_any) begin
                req_q  <= {pmem_read, pmem_write};
                addr_q <= pmem_address;
                if ((pmem_read && pmem_write) || (pmem_address[4:0] != 5'd0)) begin
                    err_q <= 1'b1;
                end
            end
            if ((state_q == WAIT || state_q == BURST) &&
                (({pmem_read, pmem_write} != req_q) || (pmem_address != addr_q))) begin
                err_q <= 1'b1;
            end
        end
    end

    assign pmem_err = err_q;
`else
    logic unused_addr_bits;
    assign unused_addr_bits = ^{pmem_address[31:LINE_IDX_BITS+5], pmem_address[4:0]};
    assign pmem_err = 1'b0;
`endif

endmodule

// File: tb/tb_pmem_burst_responder.sv
// tb/tb_pmem_burst_responder.sv - directed table-driven bench for pmem_burst_responder.
module tb_pmem_burst_responder;

    logic        clk;
    logic        rst;
    logic        a_read, a_write, b_read, b_write;
    logic [31:0] a_addr, b_addr;
    logic [63:0] a_wdata, b_wdata, a_rdata, b_rdata;
    logic        a_resp, b_resp, a_err, b_err;

    int checks;
    int failures;

    pmem_burst_responder #(.LINE_IDX_BITS(8), .LATENCY(10)) dut_a (
        .clk(clk), .rst(rst), .pmem_read(a_read), .pmem_write(a_write),
        .pmem_address(a_addr), .pmem_wdata(a_wdata), .pmem_rdata(a_rdata),
        .pmem_resp(a_resp), .pmem_err(a_err)
    );

    pmem_burst_responder #(.LINE_IDX_BITS(4), .LATENCY(1)) dut_b (
        .clk(clk), .rst(rst), .pmem_read(b_read), .pmem_write(b_write),
        .pmem_address(b_addr), .pmem_wdata(b_wdata), .pmem_rdata(b_rdata),
        .pmem_resp(b_resp), .pmem_err(b_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef logic [3:0][63:0] beats_t;
    typedef struct {
        bit          wr;
        logic [31:0] addr;
        beats_t      d;
    } vec_t;

    vec_t tbl[8];

`ifdef PMEM_PROTOCOL_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic set_req(input bit sel, input bit rd, input bit wr, input logic [31:0] addr);
        if (sel) begin
            b_read = rd; b_write = wr; b_addr = addr;
        end else begin
            a_read = rd; a_write = wr; a_addr = addr;
        end
    endtask

    // One transaction; expected resp window and read data come from the bench's own timing model.
    task automatic txn(input bit sel, input bit rd, input bit wr, input logic [31:0] addr,
                       input beats_t d, input bit chk_rd, input int rst_beat, input int hold,
                       input string name);
        int lat, last, drop_c, end_c;
        logic r;
        logic [63:0] rv;
        lat    = sel ? 1 : 10;
        last   = (rst_beat >= 0) ? lat + rst_beat : lat + 3;
        drop_c = (rst_beat >= 0) ? lat + rst_beat + 1 : lat + 4 + hold;
        end_c  = drop_c + 2;
        set_req(sel, rd, wr, addr);
        @(posedge clk);
        for (int c = 1; c <= end_c; c++) begin
            @(negedge clk);
            r  = sel ? b_resp : a_resp;
            rv = sel ? b_rdata : a_rdata;
            chk($sformatf("%s_resp_c%0d", name, c), {63'h0, r}, {63'h0, (c >= lat && c <= last)});
            if (c >= lat && c <= last) begin
                if (chk_rd) chk($sformatf("%s_rdata_b%0d", name, c - lat), rv, d[c - lat]);
            end else begin
                chk($sformatf("%s_rdata_idle_c%0d", name, c), rv, 64'h0);
            end
            if (c >= lat && c <= lat + 3) begin
                if (sel) b_wdata = d[c - lat];
                else     a_wdata = d[c - lat];
            end
            if (rst_beat >= 0 && c == lat + rst_beat) rst = 1'b1;
            if (c == drop_c) begin
                rst = 1'b0;
                set_req(sel, 1'b0, 1'b0, 32'h0);
            end
        end
    endtask

    beats_t dz, dnew, dboth, dbw;

    initial begin
        checks   = 0;
        failures = 0;
        rst = 1'b1;
        a_read = 0; a_write = 0; a_addr = 0; a_wdata = 0;
        b_read = 0; b_write = 0; b_addr = 0; b_wdata = 0;

        tbl[0] = '{1'b1, 32'h0000_0040, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                         64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}};
        tbl[1] = '{1'b0, 32'h0000_0040, tbl[0].d};
        tbl[2] = '{1'b1, 32'h0000_0080, {64'hDDDD_0000_0000_0003, 64'hCCCC_0000_0000_0002,
                                         64'hBBBB_0000_0000_0001, 64'hAAAA_0000_0000_0000}};
        tbl[3] = '{1'b0, 32'h0000_0080, tbl[2].d};
        tbl[4] = '{1'b0, 32'h0000_0040, tbl[0].d};
        tbl[5] = '{1'b1, 32'h0000_2040, {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                                         64'hA5A5_A5A5_5A5A_5A5A, 64'h0F0F_F0F0_0F0F_F0F0}};
        tbl[6] = '{1'b0, 32'h0000_0040, tbl[5].d};
        tbl[7] = '{1'b0, 32'h0000_0080, tbl[2].d};

        dz    = '0;
        dnew  = {64'h9999_0000_0000_0003, 64'h8888_0000_0000_0002,
                 64'h7777_0000_0000_0001, 64'h6666_0000_0000_0000};
        dboth = {64'hB0B0_0000_0000_0003, 64'hB0B0_0000_0000_0002,
                 64'hB0B0_0000_0000_0001, 64'hB0B0_0000_0000_0000};
        dbw   = {64'h0000_0000_CAFE_0003, 64'h0000_0000_CAFE_0002,
                 64'h0000_0000_CAFE_0001, 64'h0000_0000_CAFE_0000};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_resp", {63'h0, a_resp}, 64'h0);
        chk("reset_rdata", a_rdata, 64'h0);
        chk("reset_err", {63'h0, a_err}, 64'h0);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk($sformatf("idle_resp_%0d", i), {63'h0, a_resp}, 64'h0);
            chk($sformatf("idle_rdata_%0d", i), a_rdata, 64'h0);
        end

        for (int i = 0; i < 8; i++) begin
            txn(1'b0, !tbl[i].wr, tbl[i].wr, tbl[i].addr, tbl[i].d, !tbl[i].wr, -1, 0,
                $sformatf("vec%0d", i));
        end
        chk("clean_err", {63'h0, a_err}, 64'h0);

        // Read and write together: write wins, checker flags it if built.
        txn(1'b0, 1'b1, 1'b1, 32'h0000_00C0, dboth, 1'b0, -1, 0, "both_wr");
        chk("both_err_set", {63'h0, a_err}, {63'h0, EXP_ERR});
        txn(1'b0, 1'b1, 1'b0, 32'h0000_00C0, dboth, 1'b1, -1, 0, "both_rd");
        chk("both_err_sticky", {63'h0, a_err}, {63'h0, EXP_ERR});
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("err_cleared", {63'h0, a_err}, 64'h0);

        // Reset during beat 2 of a write to line 0x80 (holding tbl[2] data).
        txn(1'b0, 1'b0, 1'b1, 32'h0000_0080, dnew, 1'b0, 2, 0, "rst_wr");
        txn(1'b0, 1'b1, 1'b0, 32'h0000_0080, {tbl[2].d[3], tbl[2].d[2], dnew[1], dnew[0]},
            1'b1, -1, 0, "rst_rd");

        // LATENCY=1 instance: resp on edges t+1..t+4, held request in DONE yields no rerun.
        txn(1'b1, 1'b0, 1'b1, 32'h0000_0020, dbw, 1'b0, -1, 0, "l1_wr");
        txn(1'b1, 1'b1, 1'b0, 32'h0000_0020, dbw, 1'b1, -1, 3, "l1_rd_hold");
        chk("l1_err", {63'h0, b_err}, 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
